// File: rtl/mem_pkg.sv
// Shared types for the memory read streamer.
// Holds the controller state encoding.
package mem_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_e;

endpackage

// File: rtl/mem_rd_stream_if.sv
// Output stream handshake bundle.
// master drives valid/data/last, slave drives ready.
interface mem_rd_stream_if #(
  parameter int WIDTH = 32
);

  logic             m_valid;
  logic             m_ready;
  logic [WIDTH-1:0] m_data;
  logic             m_last;

  modport master (
    output m_valid, m_data, m_last,
    input  m_ready
  );

  modport slave (
    input  m_valid, m_data, m_last,
    output m_ready
  );

endinterface

// File: rtl/sync_fifo.sv
// Small synchronous FIFO holding data plus a last flag.
// push_i/wdata_i/wlast_i in, pop_i/rdata_o/rlast_o/empty_o out.
module sync_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic             wlast_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic             rlast_o,
  output logic             empty_o
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [WIDTH:0]  mem_q [DEPTH];
  logic [PW-1:0]   wr_q, rd_q;
  logic [CW-1:0]   cnt_q;
  logic            full, do_push, do_pop;

  function automatic logic [PW-1:0] inc(
    input logic [PW-1:0] p
  );
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign empty_o = (cnt_q == '0);
  assign full    = (cnt_q == CW'(DEPTH));
  assign do_pop  = pop_i && !empty_o;
  // a full FIFO may still accept when the head leaves this cycle
  assign do_push = push_i && (!full || do_pop);

  // head is zeroed when empty so stale words never leak out
  assign {rlast_o, rdata_o} =
    empty_o ? '0 : mem_q[rd_q];

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (do_push) begin
        mem_q[wr_q] <= {wlast_i, wdata_i};
        wr_q        <= inc(wr_q);
      end
      if (do_pop) rd_q <= inc(rd_q);
      cnt_q <= cnt_q + CW'(do_push) - CW'(do_pop);
    end
  end

endmodule

// File: rtl/mem_rd_stream.sv
// Streams a burst of words from a memory read port.
// start/base_addr/len cmd, busy/done status,
// enB/addrB/doutB mem port B, m stream out.
module mem_rd_stream
  import mem_pkg::*;
#(
  parameter int WIDTH  = 32,
  parameter int DEPTH  = 512,
  parameter int RD_LAT = 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic [$clog2(DEPTH)-1:0] base_addr,
  input  logic [$clog2(DEPTH):0]   len,
  output logic                     busy,
  output logic                     done,
  output logic                     enB,
  output logic [$clog2(DEPTH)-1:0] addrB,
  input  logic [WIDTH-1:0]         doutB,
  mem_rd_stream_if.master          m
);

  localparam int AW  = $clog2(DEPTH);
  localparam int LW  = AW + 1;
  localparam int CAP = RD_LAT + 1;
  localparam int OW  = $clog2(CAP + 1);

  state_e           state_q;
  logic [AW-1:0]    ptr_q, last_addr_q;
  logic [LW-1:0]    len_q, iss_q;
  logic [OW-1:0]    out_q;
  logic [RD_LAT-1:0] fl_v_q, fl_l_q;
  logic             busy_q, done_q;

  logic             go, room, run_en, pop;
  logic             f_empty, rd_last, idle;
  logic [AW-1:0]    rd_addr;
  logic [LW-1:0]    rd_idx, rd_len;

  function automatic logic [AW-1:0] nxt(
    input logic [AW-1:0] a
  );
    return (a == AW'(DEPTH - 1)) ? '0 : a + 1'b1;
  endfunction

  assign idle = (state_q == IDLE);
  assign go   = idle && start && !rst;
  assign pop  = m.m_valid && m.m_ready;

  // out_q counts words buffered plus reads in flight;
  // a word leaving this cycle frees its slot for a new read
  assign room = 32'(out_q) < 32'(CAP) + 32'(pop);

  assign run_en = !idle && !rst && room &&
                  (iss_q < len_q);

  // the first read goes out in the start cycle itself
  assign enB = (go && (len != '0)) || run_en;

  assign rd_addr = idle ? base_addr : ptr_q;
  assign rd_idx  = idle ? '0 : iss_q;
  assign rd_len  = idle ? len : len_q;
  assign rd_last = (rd_idx == rd_len - 1'b1);
  assign addrB   = enB ? rd_addr : last_addr_q;

  assign busy = busy_q;
  assign done = done_q;
  assign m.m_valid = !f_empty;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      ptr_q       <= '0;
      last_addr_q <= '0;
      len_q       <= '0;
      iss_q       <= '0;
      out_q       <= '0;
      fl_v_q      <= '0;
      fl_l_q      <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (enB) begin
        last_addr_q <= rd_addr;
        ptr_q       <= nxt(rd_addr);
        iss_q       <= rd_idx + 1'b1;
      end
      out_q  <= out_q + OW'(enB) - OW'(pop);
      fl_v_q <= (fl_v_q << 1) | RD_LAT'(enB);
      fl_l_q <= (fl_l_q << 1) |
                RD_LAT'(enB && rd_last);
      unique case (state_q)
        IDLE: begin
          if (go) begin
            if (len != '0) begin
              state_q <= RUN;
              len_q   <= len;
              busy_q  <= 1'b1;
            end else begin
              done_q  <= 1'b1;
            end
          end
        end
        RUN: begin
          if (pop && m.m_last) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end
        end
      endcase
    end
  end

  sync_fifo #(
    .WIDTH (WIDTH),
    .DEPTH (CAP)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (fl_v_q[RD_LAT-1]),
    .wdata_i (doutB),
    .wlast_i (fl_l_q[RD_LAT-1]),
    .pop_i   (pop),
    .rdata_o (m.m_data),
    .rlast_o (m.m_last),
    .empty_o (f_empty)
  );

endmodule

// File: doc/mem_rd_stream.md
MEM_RD_STREAM -- requirements
Module: mem_rd_stream

Interface
REQ-001 SHALL have parameter WIDTH, default 32, data word width in bits.
REQ-002 SHALL have parameter DEPTH, default 512, word depth of the attached parametric memory.
REQ-003 SHALL have parameter RD_LAT, default 1, memory read latency in cycles from enB to valid doutB.
REQ-004 SHALL have port clk  in  1  single clock for all logic.
REQ-005 SHALL have port rst  in  1  reset, synchronous, active-high.
REQ-006 SHALL have port start  in  1  one-cycle command pulse.
REQ-007 SHALL have port base_addr  in  $clog2(DEPTH)  first word address.
REQ-008 SHALL have port len  in  $clog2(DEPTH)+1  word count, 0..DEPTH.
REQ-009 SHALL have port busy  out  1  burst in progress.
REQ-010 SHALL have port done  out  1  one-cycle pulse after the last word handshakes.
REQ-011 SHALL have port enB  out  1  memory read enable.
REQ-012 SHALL have port addrB  out  $clog2(DEPTH)  memory read address.
REQ-013 SHALL have port doutB  in  WIDTH  memory read data.
REQ-014 SHALL have port m_valid  out  1  stream data valid.
REQ-015 SHALL have port m_ready  in  1  stream consumer ready.
REQ-016 SHALL have port m_data  out  WIDTH  stream data.
REQ-017 SHALL have port m_last  out  1  marks the final word of the burst.

Function
REQ-018 SHALL implement states IDLE and RUN; IDLE->RUN on start with len>0; RUN->IDLE when the final word handshakes (m_valid & m_ready & m_last).
REQ-019 SHALL, on start with len==0 in IDLE, pulse done on the next cycle, issue no reads, and stay in IDLE.
REQ-020 SHALL latch base_addr and len on start; start while busy SHALL be ignored.
REQ-021 SHALL issue read k (k=0..len-1) at address (base_addr+k) mod DEPTH; the address SHALL wrap from DEPTH-1 to 0.
REQ-022 SHALL buffer returned data in an output FIFO of RD_LAT+1 entries.
REQ-023 SHALL assert enB only when (FIFO occupancy + reads in flight) < RD_LAT+1 and issued < len, so no returned word is ever dropped.
REQ-024 SHALL track in-flight reads with an RD_LAT-deep valid shift register; its tail SHALL write doutB into the FIFO.
REQ-025 SHALL drive m_valid = FIFO non-empty and m_data = FIFO head; data SHALL be held stable while m_valid & !m_ready.
REQ-026 SHALL assert m_last with the word whose index is len-1.
REQ-027 SHALL sustain one word per cycle when m_ready is held high; first m_valid SHALL occur RD_LAT+1 cycles after start.
REQ-028 SHALL support FIFO push and pop in the same cycle, with occupancy unchanged.
REQ-029 SHALL assert busy from the cycle after an accepted start until the cycle done pulses.
REQ-030 SHALL keep addrB at its last value when enB is low.

Reset
REQ-031 SHALL, on rst, force state IDLE and clear busy, done, enB, m_valid, m_last, addrB, all counters, FIFO pointers and in-flight bits, overriding any operation in progress; in-flight data returning after reset SHALL be discarded.
REQ-032 SHALL ignore start in the same cycle as rst.

Structure
REQ-033 SHALL define the state enum type in the shared package mem_pkg.
REQ-034 SHALL contain one sub-module, sync_fifo (parameters WIDTH and DEPTH=RD_LAT+1), which holds data plus the last flag.
REQ-035 SHALL be connected directly to the port B of the parametric memory; clkB and clkA of that memory SHALL both be tied to clk.

Verification
REQ-036 SHALL check: base=0, len=4, m_ready=1 -> m_data = mem[0..3] on consecutive cycles, m_last on the 4th word, done 1 cycle later.
REQ-037 SHALL check: base=DEPTH-2, len=4 -> addresses DEPTH-2, DEPTH-1, 0, 1 are read in order.
REQ-038 SHALL check: len=8 with m_ready toggled randomly -> all 8 words arrive in order with no loss or duplication, and enB never runs past capacity.
REQ-039 SHALL check: len=0 -> done pulses 1 cycle later, enB stays 0 and m_valid stays 0.
REQ-040 SHALL check: rst asserted mid-burst after 3 of 8 words -> next cycle all outputs are 0, and a new start with base=5, len=2 returns mem[5], mem[6] only.
REQ-041 SHALL check: a second start pulse while busy -> it is ignored and the original burst completes unchanged.
